// File: rtl/graphics_tile_renderer.sv
// rtl/graphics_tile_renderer.sv - tile-map VGA pixel colour generator with blinking robot tile
// Optional grid-line overlay is enabled by defining GRID_LINES_EN.
module graphics_tile_renderer #(
   parameter int MAX_X       = 640,
   parameter int MAX_Y       = 480,
   parameter int TILE_SHIFT  = 6,
   parameter int COLS        = 10,
   parameter int ROWS        = 7,
   parameter int BLINK_SHIFT = 4
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       video_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       map_we,
   input  logic [6:0] map_addr,
   input  logic [1:0] map_data,
   input  logic       pos_valid,
   output logic       pos_ready,
   input  logic [3:0] pos_col,
   input  logic [2:0] pos_row,
   output logic [7:0] graph_r,
   output logic [7:0] graph_g,
   output logic [7:0] graph_b
);

   localparam int CELLS = COLS * ROWS;

   logic [1:0]  map_mem [CELLS];
   logic [9:0]  col_c, row_c;
   logic        in_grid_c, boundary;
   logic [6:0]  rd_idx;

   logic        v1, in_grid1;
   logic [3:0]  col1;
   logic [2:0]  row1;
   logic [1:0]  tile1;
`ifdef GRID_LINES_EN
   logic        line1;
`endif

   logic [3:0]  robot_col, pend_col;
   logic [2:0]  robot_row, pend_row;
   logic        pend_full;
   logic [BLINK_SHIFT:0] frame_cnt;
   logic [23:0] rgb_next;

   assign col_c     = pix_x >> TILE_SHIFT;
   assign row_c     = pix_y >> TILE_SHIFT;
   assign in_grid_c = (col_c < 10'(COLS)) && (row_c < 10'(ROWS)) &&
                      (pix_x < 10'(MAX_X)) && (pix_y < 10'(MAX_Y));
   assign rd_idx    = 7'(row_c[2:0]) * 7'(COLS) + 7'(col_c[3:0]);
   assign boundary  = (pix_x == 10'd0) && (pix_y == 10'(MAX_Y));
   assign pos_ready = !pend_full;

   // S1: tile lookup; the NBA write below leaves this read returning the old code
   always_ff @(posedge clock_25) begin
      if (reset) begin
         v1       <= 1'b0;
         in_grid1 <= 1'b0;
         col1     <= '0;
         row1     <= '0;
         tile1    <= '0;
`ifdef GRID_LINES_EN
         line1    <= 1'b0;
`endif
         for (int i = 0; i < CELLS; i++) map_mem[i] <= '0;
      end else begin
         v1       <= video_on;
         in_grid1 <= in_grid_c;
         col1     <= col_c[3:0];
         row1     <= row_c[2:0];
         tile1    <= in_grid_c ? map_mem[rd_idx] : 2'd0;
`ifdef GRID_LINES_EN
         line1    <= in_grid_c && ((pix_x[TILE_SHIFT-1:0] == '0) || (pix_y[TILE_SHIFT-1:0] == '0));
`endif
         if (map_we && (map_addr < 7'(CELLS)))
            map_mem[map_addr] <= map_data;
      end
   end

   // Robot position only moves at a frame boundary so a frame never tears
   always_ff @(posedge clock_25) begin
      if (reset) begin
         robot_col <= '0;
         robot_row <= '0;
         pend_col  <= '0;
         pend_row  <= '0;
         pend_full <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (boundary) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (pend_full) begin
               robot_col <= pend_col;
               robot_row <= pend_row;
               pend_full <= 1'b0;
            end
         end
         if (pos_valid && !pend_full) begin
            pend_col  <= pos_col;
            pend_row  <= pos_row;
            pend_full <= 1'b1;
         end
      end
   end

   always_comb begin
      rgb_next = 24'h000000;
      if (!v1)
         rgb_next = 24'h000000;
      else if (in_grid1 && (col1 == robot_col) && (row1 == robot_row) && !frame_cnt[BLINK_SHIFT])
         rgb_next = 24'hFF0000;
`ifdef GRID_LINES_EN
      else if (line1)
         rgb_next = 24'h404040;
`endif
      else if (!in_grid1)
         rgb_next = 24'h808000;
      else begin
         case (tile1)
            2'd0:    rgb_next = 24'h808000;
            2'd1:    rgb_next = 24'h000081;
            2'd2:    rgb_next = 24'h604000;
            default: rgb_next = 24'hA0A0A0;
         endcase
      end
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         graph_r <= '0;
         graph_g <= '0;
         graph_b <= '0;
      end else begin
         graph_r <= rgb_next[23:16];
         graph_g <= rgb_next[15:8];
         graph_b <= rgb_next[7:0];
      end
   end

endmodule

// File: tb/tb_graphics_tile_renderer.sv
// tb/tb_graphics_tile_renderer.sv - table, directed and random checks of graphics_tile_renderer
// Grid-line expectations follow GRID_LINES_EN.
module tb_graphics_tile_renderer;

   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] OLIVE = 24'h808000;
   localparam logic [23:0] BLUE  = 24'h000081;
   localparam logic [23:0] DIRTY = 24'h604000;
   localparam logic [23:0] CLEAN = 24'hA0A0A0;
   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREY  = 24'h404040;

   logic       clock_25 = 1'b0;
   logic       reset, video_on, map_we, pos_valid, pos_ready;
   logic [9:0] pix_x, pix_y;
   logic [6:0] map_addr;
   logic [1:0] map_data;
   logic [3:0] pos_col;
   logic [2:0] pos_row;
   logic [7:0] graph_r, graph_g, graph_b;

   int nvec = 0;
   int nbad = 0;

   always #20 clock_25 = ~clock_25;

   graphics_tile_renderer dut (
      .clock_25(clock_25), .reset(reset), .video_on(video_on),
      .pix_x(pix_x), .pix_y(pix_y),
      .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
      .pos_valid(pos_valid), .pos_ready(pos_ready),
      .pos_col(pos_col), .pos_row(pos_row),
      .graph_r(graph_r), .graph_g(graph_g), .graph_b(graph_b)
   );

   // Reference model: map array, robot/pending slot, frame count, and the one sampled pixel in flight
   int          m_map [70];
   int          m_rc, m_rr, m_pc, m_pr, m_fcnt;
   bit          m_pfull;
   bit          s1_v;
   int          s1_x, s1_y, s1_tile;
   logic [23:0] m_out;

   function automatic logic [23:0] colour(bit v, int x, int y, int t, int rcol, int rrow, bit vis);
      int c = x / 64;
      int r = y / 64;
      bit ing = (c < 10) && (r < 7);
      if (!v) return BLACK;
      if (ing && vis && c == rcol && r == rrow) return RED;
`ifdef GRID_LINES_EN
      if (ing && ((x % 64) == 0 || (y % 64) == 0)) return GREY;
`endif
      if (!ing) return OLIVE;
      case (t)
         0:       return OLIVE;
         1:       return BLUE;
         2:       return DIRTY;
         default: return CLEAN;
      endcase
   endfunction

   task automatic model_edge();
      int  x, y, c, r;
      bit  old_full;
      if (reset) begin
         for (int i = 0; i < 70; i++) m_map[i] = 0;
         m_rc = 0; m_rr = 0; m_pc = 0; m_pr = 0; m_fcnt = 0; m_pfull = 0;
         s1_v = 0; s1_x = 0; s1_y = 0; s1_tile = 0;
         m_out = BLACK;
         return;
      end
      m_out = colour(s1_v, s1_x, s1_y, s1_tile, m_rc, m_rr, m_fcnt < 16);
      x = int'(pix_x);
      y = int'(pix_y);
      c = x / 64;
      r = y / 64;
      s1_v    = video_on;
      s1_x    = x;
      s1_y    = y;
      s1_tile = (c < 10 && r < 7) ? m_map[r * 10 + c] : 0;
      old_full = m_pfull;
      if (x == 0 && y == 480) begin
         m_fcnt = (m_fcnt + 1) % 32;
         if (old_full) begin
            m_rc = m_pc; m_rr = m_pr; m_pfull = 0;
         end
      end
      if (pos_valid && !old_full) begin
         m_pc = int'(pos_col); m_pr = int'(pos_row); m_pfull = 1;
      end
      if (map_we && map_addr < 7'd70) m_map[map_addr] = int'(map_data);
   endtask

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and compare against the model
   task automatic step(input bit rst, input bit v, input int x, input int y,
                       input bit we, input int addr, input int data,
                       input bit pv, input int pc, input int pr);
      reset     = rst;
      video_on  = v;
      pix_x     = 10'(x);
      pix_y     = 10'(y);
      map_we    = we;
      map_addr  = 7'(addr);
      map_data  = 2'(data);
      pos_valid = pv;
      pos_col   = 4'(pc);
      pos_row   = 3'(pr);
      @(posedge clock_25);
      model_edge();
      @(negedge clock_25);
      check("model_rgb", {graph_r, graph_g, graph_b}, m_out);
      check("model_ready", {23'd0, pos_ready}, {23'd0, !m_pfull});
   endtask

   typedef struct {
      bit          v;
      int          x;
      int          y;
      bit          we;
      int          addr;
      int          data;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(bit v, int x, int y, bit we, int addr, int data, logic [23:0] exp);
      vec_t t;
      t.v = v; t.x = x; t.y = y; t.we = we; t.addr = addr; t.data = data; t.exp = exp;
      return t;
   endfunction

   initial begin
      logic [23:0] line_exp;
`ifdef GRID_LINES_EN
      line_exp = GREY;
`else
      line_exp = OLIVE;
`endif
      // Each row's exp is the colour visible after that row's edge (reflects the previous row)
      tbl[0]  = mk(1, 100, 100, 0,  0, 0, BLACK);
      tbl[1]  = mk(1, 100, 100, 0,  0, 0, OLIVE);
      tbl[2]  = mk(0, 100, 100, 0,  0, 0, OLIVE);
      tbl[3]  = mk(0, 100, 100, 0,  0, 0, BLACK);
      tbl[4]  = mk(1,  70,  70, 1, 11, 1, BLACK);
      tbl[5]  = mk(1,  70,  70, 0,  0, 0, OLIVE);
      tbl[6]  = mk(1,  70,  70, 1, 11, 2, BLUE);
      tbl[7]  = mk(1,  70,  70, 0,  0, 0, BLUE);
      tbl[8]  = mk(1,  70,  70, 0,  0, 0, DIRTY);
      tbl[9]  = mk(1,  10, 460, 1, 70, 3, DIRTY);
      tbl[10] = mk(1,  70,  70, 0,  0, 0, OLIVE);
      tbl[11] = mk(1,  30,  30, 0,  0, 0, DIRTY);
      tbl[12] = mk(1, 128,  30, 0,  0, 0, RED);
      tbl[13] = mk(1, 128,  30, 0,  0, 0, line_exp);

      @(negedge clock_25);
      step(1, 1, 100, 100, 0, 0, 0, 0, 0, 0);
      step(1, 1, 100, 100, 0, 0, 0, 0, 0, 0);
      check("reset_rgb", {graph_r, graph_g, graph_b}, BLACK);
      check("reset_ready", {23'd0, pos_ready}, 24'd1);

      for (int i = 0; i < 14; i++) begin
         step(0, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].we, tbl[i].addr, tbl[i].data, 0, 0, 0);
         check($sformatf("table_%0d", i), {graph_r, graph_g, graph_b}, tbl[i].exp);
      end

      // Position handshake: held off until the frame boundary
      step(0, 1, 200, 140, 0, 0, 0, 1, 3, 2);
      check("ready_drop", {23'd0, pos_ready}, 24'd0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      check("robot_not_moved", {graph_r, graph_g, graph_b}, OLIVE);
      step(0, 0, 0, 480, 0, 0, 0, 0, 0, 0);
      check("ready_rise", {23'd0, pos_ready}, 24'd1);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      check("robot_moved", {graph_r, graph_g, graph_b}, RED);

      // Blink: frame count is 1 here; 15 more boundaries reach 16 (hidden), 16 more wrap to 0
      for (int i = 0; i < 15; i++) step(0, 0, 0, 480, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      check("blink_off", {graph_r, graph_g, graph_b}, OLIVE);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 480, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      step(0, 1, 200, 140, 0, 0, 0, 0, 0, 0);
      check("blink_on", {graph_r, graph_g, graph_b}, RED);

      // Transfer on the same edge as a boundary waits for the next boundary
      step(0, 0, 0, 480, 0, 0, 0, 1, 5, 1);
      step(0, 1, 330, 70, 0, 0, 0, 0, 0, 0);
      step(0, 1, 330, 70, 0, 0, 0, 0, 0, 0);
      check("same_edge_not_applied", {graph_r, graph_g, graph_b}, OLIVE);
      check("same_edge_pending", {23'd0, pos_ready}, 24'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         int x, y, sel;
         sel = int'($urandom_range(0, 7));
         if (sel == 0) begin
            x = 0; y = 480;
         end else if (sel == 1) begin
            x = 64 * int'($urandom_range(0, 11)); y = int'($urandom_range(0, 524));
         end else begin
            x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524));
         end
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) != 0), x, y,
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
